// File: rtl/ysyx_25040129_trap_seq_pkg.sv
// Shared constants for the machine-mode trap/return sequencer:
// CSR addresses, mstatus bit positions, sequencer state encodings and a
// small PC alignment helper.
package ysyx_25040129_trap_seq_pkg;

  // Machine-mode CSR addresses
  localparam logic [11:0] YSYX_25040129_MSTATUS = 12'h300;
  localparam logic [11:0] YSYX_25040129_MTVEC   = 12'h305;
  localparam logic [11:0] YSYX_25040129_MEPC    = 12'h341;
  localparam logic [11:0] YSYX_25040129_MCAUSE  = 12'h342;

  // mstatus bit positions
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // Sequencer states
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_W_EPC    = 3'd1;
  localparam logic [2:0] ST_W_CAUSE  = 3'd2;
  localparam logic [2:0] ST_W_STATUS = 3'd3;
  localparam logic [2:0] ST_T_REDIR  = 3'd4;
  localparam logic [2:0] ST_M_STATUS = 3'd5;
  localparam logic [2:0] ST_M_REDIR  = 3'd6;

  // Clear the two low bits of a PC-like value (word alignment)
  function automatic logic [31:0] align4(input logic [31:0] value);
    return {value[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ysyx_25040129_trap_seq_mstatus_stack.sv
// Combinational mstatus interrupt-enable stack transform.
// Trap: MPIE<=MIE, MIE<=0, MPP<=11. Mret: MIE<=MPIE, MPIE<=1, MPP<=11.
// All other bits pass through unchanged.
// Only compiled when YSYX_25040129_MSTATUS_STACK_EN is defined.
`ifdef YSYX_25040129_MSTATUS_STACK_EN
module ysyx_25040129_mstatus_stack
  import ysyx_25040129_trap_seq_pkg::*;
(
  input  logic        is_mret,
  input  logic [31:0] mstatus_in,
  output logic [31:0] mstatus_out
);

  // Push or pop the interrupt-enable stack depending on the sequence kind
  always_comb begin
    mstatus_out = mstatus_in;
    if (is_mret) begin
      mstatus_out[MSTATUS_MIE]  = mstatus_in[MSTATUS_MPIE];
      mstatus_out[MSTATUS_MPIE] = 1'b1;
    end else begin
      mstatus_out[MSTATUS_MPIE] = mstatus_in[MSTATUS_MIE];
      mstatus_out[MSTATUS_MIE]  = 1'b0;
    end
    mstatus_out[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  end

endmodule
`endif

// File: rtl/ysyx_25040129_trap_seq.sv
// Trap/return sequencer and write-port arbiter for the machine-mode CSR file.
// Owns the CSR file's single read and write port. Traps write mepc, mcause
// (and mstatus) one per cycle, then redirect to mtvec; mret (restores
// mstatus and) redirects to mepc. Instruction CSR accesses pass through in
// IDLE and stall otherwise; a trap request wins over a same-cycle access.
// Optional mstatus stacking: define YSYX_25040129_MSTATUS_STACK_EN.
module ysyx_25040129_trap_seq
  import ysyx_25040129_trap_seq_pkg::*;
#(
  parameter int CSR_DIG = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               trap_valid,
  input  logic               trap_is_mret,
  input  logic [31:0]        trap_pc,
  input  logic [31:0]        trap_cause,
  output logic               trap_ready,
  input  logic               ins_csr_wen,
  input  logic               ins_csr_ren,
  input  logic [CSR_DIG-1:0] ins_csr_waddr,
  input  logic [CSR_DIG-1:0] ins_csr_raddr,
  input  logic [31:0]        ins_csr_wdata,
  output logic [31:0]        ins_csr_rdata,
  output logic               ins_stall,
  output logic               csr_write,
  output logic [CSR_DIG-1:0] csr_write_addr,
  output logic [31:0]        csr_data,
  output logic [CSR_DIG-1:0] csr_read_addr,
  input  logic [31:0]        csr_rdata,
  output logic               redirect_valid,
  output logic [31:0]        redirect_pc,
  output logic               busy
);

  logic [2:0]  state_r;
  logic [2:0]  state_nxt;
  logic [29:0] pc_r;     // word-aligned part of the trapping pc
  logic [31:0] cause_r;

`ifdef YSYX_25040129_MSTATUS_STACK_EN
  logic [31:0] mstatus_next;

  ysyx_25040129_mstatus_stack u_mstatus_stack (
    .is_mret     (state_r == ST_M_STATUS),
    .mstatus_in  (csr_rdata),
    .mstatus_out (mstatus_next)
  );
`endif

  // State register and request capture; reset aborts any sequence in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      pc_r    <= 30'd0;
      cause_r <= 32'd0;
    end else begin
      state_r <= state_nxt;
      if ((state_r == ST_IDLE) && trap_valid) begin
        pc_r    <= trap_pc[31:2];
        cause_r <= trap_cause;
      end
    end
  end

  // Next-state sequencing of the trap and mret flows
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE: begin
        if (trap_valid) begin
          if (trap_is_mret) begin
`ifdef YSYX_25040129_MSTATUS_STACK_EN
            state_nxt = ST_M_STATUS;
`else
            state_nxt = ST_M_REDIR;
`endif
          end else begin
            state_nxt = ST_W_EPC;
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_W_EPC: state_nxt = ST_W_CAUSE;
      ST_W_CAUSE: begin
`ifdef YSYX_25040129_MSTATUS_STACK_EN
        state_nxt = ST_W_STATUS;
`else
        state_nxt = ST_T_REDIR;
`endif
      end
      ST_W_STATUS: state_nxt = ST_T_REDIR;
      ST_T_REDIR:  state_nxt = ST_IDLE;
      ST_M_STATUS: state_nxt = ST_M_REDIR;
      ST_M_REDIR:  state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // CSR port arbitration, passthrough and redirect generation; all zero in reset
  always_comb begin
    trap_ready     = 1'b0;
    ins_csr_rdata  = 32'd0;
    ins_stall      = 1'b0;
    csr_write      = 1'b0;
    csr_write_addr = '0;
    csr_data       = 32'd0;
    csr_read_addr  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    busy           = 1'b0;
    if (rst) begin
      busy = 1'b0;
    end else begin
      busy      = (state_r != ST_IDLE);
      ins_stall = busy & (ins_csr_wen | ins_csr_ren);
      case (state_r)
        ST_IDLE: begin
          trap_ready = 1'b1;
          if (trap_valid) begin
            // trap wins: drop the instruction access and make the core hold
            ins_stall = ins_csr_wen | ins_csr_ren;
          end else begin
            csr_write      = ins_csr_wen;
            csr_write_addr = ins_csr_waddr;
            csr_data       = ins_csr_wdata;
            csr_read_addr  = ins_csr_raddr;
            ins_csr_rdata  = csr_rdata;
          end
        end
        ST_W_EPC: begin
          csr_write      = 1'b1;
          csr_write_addr = CSR_DIG'(YSYX_25040129_MEPC);
          csr_data       = {pc_r, 2'b00};
        end
        ST_W_CAUSE: begin
          csr_write      = 1'b1;
          csr_write_addr = CSR_DIG'(YSYX_25040129_MCAUSE);
          csr_data       = cause_r;
        end
`ifdef YSYX_25040129_MSTATUS_STACK_EN
        ST_W_STATUS, ST_M_STATUS: begin
          csr_read_addr  = CSR_DIG'(YSYX_25040129_MSTATUS);
          csr_write      = 1'b1;
          csr_write_addr = CSR_DIG'(YSYX_25040129_MSTATUS);
          csr_data       = mstatus_next;
        end
`endif
        ST_T_REDIR: begin
          csr_read_addr  = CSR_DIG'(YSYX_25040129_MTVEC);
          redirect_valid = 1'b1;
          redirect_pc    = align4(csr_rdata);
        end
        ST_M_REDIR: begin
          csr_read_addr  = CSR_DIG'(YSYX_25040129_MEPC);
          redirect_valid = 1'b1;
          redirect_pc    = csr_rdata;
        end
        default: begin
          redirect_valid = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25040129_trap_seq.sv
// Directed testbench for ysyx_25040129_trap_seq with a behavioural CSR file.
module tb_ysyx_25040129_trap_seq;

  logic        clk;
  logic        rst;
  logic        trap_valid;
  logic        trap_is_mret;
  logic [31:0] trap_pc;
  logic [31:0] trap_cause;
  logic        trap_ready;
  logic        ins_csr_wen;
  logic        ins_csr_ren;
  logic [11:0] ins_csr_waddr;
  logic [11:0] ins_csr_raddr;
  logic [31:0] ins_csr_wdata;
  logic [31:0] ins_csr_rdata;
  logic        ins_stall;
  logic        csr_write;
  logic [11:0] csr_write_addr;
  logic [31:0] csr_data;
  logic [11:0] csr_read_addr;
  logic [31:0] csr_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  int n_vec;
  int n_err;
  int redir_cnt;

`ifdef YSYX_25040129_MSTATUS_STACK_EN
  localparam int TRAP_LAT = 4;
  localparam int MRET_LAT = 2;
`else
  localparam int TRAP_LAT = 3;
  localparam int MRET_LAT = 1;
`endif

  ysyx_25040129_trap_seq #(.CSR_DIG(12)) dut (
    .clk            (clk),
    .rst            (rst),
    .trap_valid     (trap_valid),
    .trap_is_mret   (trap_is_mret),
    .trap_pc        (trap_pc),
    .trap_cause     (trap_cause),
    .trap_ready     (trap_ready),
    .ins_csr_wen    (ins_csr_wen),
    .ins_csr_ren    (ins_csr_ren),
    .ins_csr_waddr  (ins_csr_waddr),
    .ins_csr_raddr  (ins_csr_raddr),
    .ins_csr_wdata  (ins_csr_wdata),
    .ins_csr_rdata  (ins_csr_rdata),
    .ins_stall      (ins_stall),
    .csr_write      (csr_write),
    .csr_write_addr (csr_write_addr),
    .csr_data       (csr_data),
    .csr_read_addr  (csr_read_addr),
    .csr_rdata      (csr_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy)
  );

  // Behavioural CSR file: combinational read, write on the clock edge
  logic [31:0] csr_mem [0:4095];
  assign csr_rdata = csr_mem[csr_read_addr];

  always @(posedge clk) begin
    if (csr_write) csr_mem[csr_write_addr] <= csr_data;
  end

  // Count redirect pulses seen at clock edges
  always @(posedge clk) begin
    if (rst) redir_cnt <= redir_cnt;
    else if (redirect_valid) redir_cnt <= redir_cnt + 1;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    trap_valid    = 1'b0;
    trap_is_mret  = 1'b0;
    trap_pc       = 32'd0;
    trap_cause    = 32'd0;
    ins_csr_wen   = 1'b0;
    ins_csr_ren   = 1'b0;
    ins_csr_waddr = 12'd0;
    ins_csr_raddr = 12'd0;
    ins_csr_wdata = 32'd0;
  endtask

  task automatic ins_write(input logic [11:0] a, input logic [31:0] d);
    ins_csr_wen   = 1'b1;
    ins_csr_waddr = a;
    ins_csr_wdata = d;
    step();
    ins_csr_wen   = 1'b0;
    #1;
  endtask

  // Starting in the first busy cycle, check the busy-state outputs every
  // cycle and locate the redirect pulse; leaves the bench in IDLE.
  task automatic wait_redirect(input string tag, input int exp_lat, input logic [31:0] exp_pc);
    int lat;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      check({tag, "_ready"}, {31'd0, trap_ready}, 32'd0);
      check({tag, "_stall"}, {31'd0, ins_stall}, {31'd0, ins_csr_wen | ins_csr_ren});
      check({tag, "_rdata"}, ins_csr_rdata, 32'd0);
      if (redirect_valid) begin
        lat = k;
        check({tag, "_pc"}, redirect_pc, exp_pc);
        check({tag, "_wr_in_redir"}, {31'd0, csr_write}, 32'd0);
        break;
      end
      step();
    end
    check({tag, "_latency"}, lat, exp_lat);
    step();
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int rc;
    n_vec = 0;
    n_err = 0;
    redir_cnt = 0;
    idle_inputs();
    rst = 1'b1;
    // Requests during reset must see every output at zero
    trap_valid  = 1'b1;
    ins_csr_wen = 1'b1;
    ins_csr_ren = 1'b1;
    #12;
    check("rst_ready", {31'd0, trap_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wr", {31'd0, csr_write}, 32'd0);
    check("rst_stall", {31'd0, ins_stall}, 32'd0);
    check("rst_redir", {31'd0, redirect_valid}, 32'd0);
    idle_inputs();
    step();
    rst = 1'b0;
    #1;
    check("idle_ready", {31'd0, trap_ready}, 32'd1);

    // 1. Idle passthrough write then read of mtvec
    ins_csr_wen   = 1'b1;
    ins_csr_waddr = 12'h305;
    ins_csr_wdata = 32'h80000100;
    #1;
    check("pt_wen", {31'd0, csr_write}, 32'd1);
    check("pt_waddr", {20'd0, csr_write_addr}, 32'h305);
    check("pt_wdata", csr_data, 32'h80000100);
    check("pt_wstall", {31'd0, ins_stall}, 32'd0);
    step();
    ins_csr_wen   = 1'b0;
    ins_csr_ren   = 1'b1;
    ins_csr_raddr = 12'h305;
    #1;
    check("pt_raddr", {20'd0, csr_read_addr}, 32'h305);
    check("pt_rdata", ins_csr_rdata, 32'h80000100);
    check("pt_rstall", {31'd0, ins_stall}, 32'd0);
    ins_csr_ren = 1'b0;

    // Known starting values for mstatus and mcause
    ins_write(12'h300, 32'h00000008);
    ins_write(12'h342, 32'h00000055);

    // 2. Trap: pc 0x80000024, cause 11
    trap_valid = 1'b1;
    trap_pc    = 32'h80000024;
    trap_cause = 32'd11;
    #1;
    check("trap_accept", {31'd0, trap_ready}, 32'd1);
    step();
    trap_valid = 1'b0;
    #1;
    wait_redirect("trap", TRAP_LAT, 32'h80000100);
    check("trap_mepc", csr_mem[12'h341], 32'h80000024);
    check("trap_mcause", csr_mem[12'h342], 32'd11);
`ifdef YSYX_25040129_MSTATUS_STACK_EN
    check("trap_mstatus", csr_mem[12'h300], 32'h00001880);
`else
    check("trap_mstatus", csr_mem[12'h300], 32'h00000008);
`endif

    // 3 + 5. mret with request held throughout the sequence
    trap_valid   = 1'b1;
    trap_is_mret = 1'b1;
    #1;
    step();
    wait_redirect("mret", MRET_LAT, 32'h80000024);
    check("held_reaccept", {31'd0, trap_ready}, 32'd1);
    trap_valid   = 1'b0;
    trap_is_mret = 1'b0;
    #1;
`ifdef YSYX_25040129_MSTATUS_STACK_EN
    check("mret_mstatus", csr_mem[12'h300], 32'h00001888);
`else
    check("mret_mstatus", csr_mem[12'h300], 32'h00000008);
`endif

    // 4. Contention: trap plus ins write to mepc in the same IDLE cycle
    trap_valid    = 1'b1;
    trap_pc       = 32'h80000047;
    trap_cause    = 32'd2;
    ins_csr_wen   = 1'b1;
    ins_csr_waddr = 12'h341;
    ins_csr_wdata = 32'h0000DEAD;
    #1;
    check("cont_stall", {31'd0, ins_stall}, 32'd1);
    check("cont_wr", {31'd0, csr_write}, 32'd0);
    step();
    trap_valid    = 1'b0;
    ins_csr_wen   = 1'b0;
    ins_csr_ren   = 1'b1;
    ins_csr_raddr = 12'h305;
    #1;
    wait_redirect("cont", TRAP_LAT, 32'h80000100);
    check("cont_release", {31'd0, ins_stall}, 32'd0);
    check("cont_rdata", ins_csr_rdata, 32'h80000100);
    check("cont_mepc", csr_mem[12'h341], 32'h80000044);
    check("cont_mcause", csr_mem[12'h342], 32'd2);
`ifdef YSYX_25040129_MSTATUS_STACK_EN
    check("cont_mstatus", csr_mem[12'h300], 32'h00001880);
`endif
    ins_csr_ren = 1'b0;

    // 6. Reset pulsed during W_CAUSE aborts the trap
    rc = redir_cnt;
    trap_valid = 1'b1;
    trap_pc    = 32'h80000100;
    trap_cause = 32'd7;
    #1;
    step();
    trap_valid = 1'b0;
    step();
    check("abort_waddr", {20'd0, csr_write_addr}, 32'h342);
    rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_redir", {31'd0, redirect_valid}, 32'd0);
    check("abort_wr", {31'd0, csr_write}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    for (int k = 0; k < 6; k++) step();
    check("abort_no_pulse", redir_cnt, rc);
    check("abort_idle", {31'd0, trap_ready}, 32'd1);
    check("abort_mepc", csr_mem[12'h341], 32'h80000100);
    check("abort_mcause", csr_mem[12'h342], 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
